// File: rtl/goofy_ctl_pkg.sv
// Shared types and defaults for the GoofyCore system controller.
package goofy_ctl_pkg;

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam int DEF_CNT_W       = 32;
  localparam int DEF_WDOG_CYCLES = 2500;

endpackage

// File: rtl/goofy_rst_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the 2nd rising edge.
module goofy_rst_sync (
  input  logic clk,
  input  logic res_n,
  output logic res_n_sync
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= 1'b1;
      sync_q <= meta_q;
    end
  end

  assign res_n_sync = sync_q;

endmodule

// File: rtl/goofy_ctl.sv
// GoofyCore system controller: core reset sequencing, clock-enable gating, halt/resume, run-cycle count.
// Optional watchdog enabled by defining GOOFY_CTL_WATCHDOG_EN.
module goofy_ctl
  import goofy_ctl_pkg::*;
#(
  parameter int RST_CYCLES  = 2,
  parameter int CNT_W       = goofy_ctl_pkg::DEF_CNT_W,
  parameter int WDOG_CYCLES = goofy_ctl_pkg::DEF_WDOG_CYCLES
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             core_hlt,
  input  logic             run_req,
  output logic             core_res,
  output logic             core_ce,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             timeout
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);

`ifdef GOOFY_CTL_WATCHDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic              res_n_sync;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              resumed_q, resumed_d;
  logic              wdog_hit;

  goofy_rst_sync u_rst_sync (
    .clk        (clk),
    .res_n      (res_n),
    .res_n_sync (res_n_sync)
  );

  assign wdog_hit = WDOG_EN && (cnt_q == WDOG_LAST);

  always_ff @(posedge clk or negedge res_n_sync) begin
    if (!res_n_sync) begin
      state_q   <= ST_RESET;
      cnt_q     <= '0;
      hold_q    <= '0;
      resumed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      resumed_q <= resumed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    resumed_d = 1'b0;
    unique case (state_q)
      ST_RESET: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        cnt_d = sat_inc(cnt_q);
        // A stale hlt seen on the first edge after a resume is not a new halt.
        if (wdog_hit) begin
          state_d = ST_TIMEOUT;
        end else if (core_hlt && !resumed_q) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (run_req) begin
          state_d   = ST_RUN;
          resumed_d = 1'b1;
        end
      end
      ST_TIMEOUT: begin
        state_d = ST_TIMEOUT;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // Core sees enabled edges in RESET only once the internal reset has released.
  assign core_res  = (state_q == ST_RESET);
  assign core_ce   = res_n_sync & ((state_q == ST_RESET) | (state_q == ST_RUN));
  assign state     = state_q;
  assign cycle_cnt = cnt_q;

`ifdef GOOFY_CTL_WATCHDOG_EN
  assign timeout = (state_q == ST_TIMEOUT);
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_goofy_ctl.sv
// Self-checking bench for goofy_ctl: reset-sequence table, directed halt/resume/watchdog/reset cases, random run vs model.
module tb_goofy_ctl;

  localparam int RST   = 2;
  localparam int CW    = 8;
  localparam int WDOG  = 20;
  localparam int CMAX  = (1 << CW) - 1;
`ifdef GOOFY_CTL_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          res_n = 1'b0;
  logic          core_hlt = 1'b0;
  logic          run_req = 1'b0;
  logic          core_res;
  logic          core_ce;
  logic [1:0]    state;
  logic [CW-1:0] cycle_cnt;
  logic          timeout;

  goofy_ctl #(.RST_CYCLES(RST), .CNT_W(CW), .WDOG_CYCLES(WDOG)) dut (
    .clk       (clk),
    .res_n     (res_n),
    .core_hlt  (core_hlt),
    .run_req   (run_req),
    .core_res  (core_res),
    .core_ce   (core_ce),
    .state     (state),
    .cycle_cnt (cycle_cnt),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: phase (0 reset,1 run,2 halted,3 timeout), edges seen since res_n rose,
  // run-cycle count, and whether the previous edge was a resume.
  int m_mode = 0;
  int m_e    = 0;
  int m_cnt  = 0;
  bit m_resumed = 1'b0;

  function automatic void model_apply(input bit rn, input bit hlt, input bit rq);
    if (!rn) begin
      m_mode = 0; m_e = 0; m_cnt = 0; m_resumed = 1'b0;
    end else begin
      case (m_mode)
        0: begin
          m_e++;
          if (m_e >= 2 + RST) m_mode = 1;
        end
        1: begin
          if (WD_ON && (m_cnt + 1 == WDOG)) m_mode = 3;
          else if (hlt && !m_resumed) m_mode = 2;
          m_resumed = 1'b0;
          if (m_cnt < CMAX) m_cnt++;
        end
        2: if (rq) begin m_mode = 1; m_resumed = 1'b1; end
        default: ;
      endcase
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    int exp_ce;
    exp_ce = (m_mode == 1 || (m_mode == 0 && m_e >= 2)) ? 1 : 0;
    chk({tag, ".state"},    int'(state),     m_mode);
    chk({tag, ".core_res"}, int'(core_res),  (m_mode == 0) ? 1 : 0);
    chk({tag, ".core_ce"},  int'(core_ce),   exp_ce);
    chk({tag, ".cnt"},      int'(cycle_cnt), m_cnt);
    chk({tag, ".timeout"},  int'(timeout),   (m_mode == 3) ? 1 : 0);
  endtask

  task automatic tick();
    bit rn, h, r;
    rn = res_n; h = core_hlt; r = run_req;
    @(posedge clk);
    model_apply(rn, h, r);
    #1;
  endtask

  task automatic chk_out(input string tag, input int st, input int ce, input int cnt);
    chk({tag, ".state"}, int'(state),     st);
    chk({tag, ".ce"},    int'(core_ce),   ce);
    chk({tag, ".cnt"},   int'(cycle_cnt), cnt);
  endtask

  typedef struct {
    bit rn; bit hlt; bit rq;
    int st; int cres; int ce; int cnt; int to;
  } vec_t;

  vec_t tbl[7];

  task automatic run_table(input string tag);
    for (int i = 0; i < 7; i++) begin
      res_n = tbl[i].rn; core_hlt = tbl[i].hlt; run_req = tbl[i].rq;
      tick();
      chk($sformatf("%s.row%0d.state", tag, i), int'(state),     tbl[i].st);
      chk($sformatf("%s.row%0d.res", tag, i),   int'(core_res),  tbl[i].cres);
      chk($sformatf("%s.row%0d.ce", tag, i),    int'(core_ce),   tbl[i].ce);
      chk($sformatf("%s.row%0d.cnt", tag, i),   int'(cycle_cnt), tbl[i].cnt);
      chk($sformatf("%s.row%0d.to", tag, i),    int'(timeout),   tbl[i].to);
    end
    core_hlt = 1'b0; run_req = 1'b0;
  endtask

  task automatic run_to(input int target, input string tag);
    for (int g = 0; g < 400 && m_cnt < target && m_mode == 1; g++) begin
      tick();
      chk_model(tag);
    end
    chk({tag, ".reached"}, int'(cycle_cnt), target);
  endtask

  task automatic async_reset(input string tag);
    res_n = 1'b0;
    #2;
    model_apply(1'b0, 1'b0, 1'b0);
    chk({tag, ".state"}, int'(state),     0);
    chk({tag, ".res"},   int'(core_res),  1);
    chk({tag, ".ce"},    int'(core_ce),   0);
    chk({tag, ".cnt"},   int'(cycle_cnt), 0);
    chk({tag, ".to"},    int'(timeout),   0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL tb_timeout: actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    //          rn  hlt rq   st res ce cnt to
    tbl[0] = '{1'b0, 1'b0, 1'b0, 0, 1, 0, 0, 0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 0, 1, 0, 0, 0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 0, 1, 1, 0, 0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 0, 1, 1, 0, 0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1, 0, 1, 0, 0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1, 0, 1, 1, 0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1, 0, 1, 2, 0};

    #3;
    chk_model("por");
    run_table("seq1");

    // Halt after 10 run cycles, then resume with hlt still high.
    run_to(10, "pre_halt");
    core_hlt = 1'b1;
    tick(); chk_out("halt", 2, 0, 11);
    tick(); chk_out("halt_hold", 2, 0, 11);
    run_req = 1'b1;
    tick(); chk_out("resume", 1, 1, 11);
    run_req = 1'b0;
    tick(); chk_out("resume_ignore", 1, 1, 12);
    tick(); chk_out("rehalt", 2, 0, 13);
    chk_model("rehalt_model");

    async_reset("rst_halted");
    run_table("seq2");
    tick(); tick(); tick();
    chk_model("run3");
    async_reset("rst_run");
    run_table("seq3");

    // Watchdog expiry.
    run_to(19, "pre_wdog");
    tick();
    if (WD_ON) begin
      chk_out("wdog", 3, 0, 20);
      chk("wdog.to", int'(timeout), 1);
      run_req = 1'b1;
      tick(); tick();
      run_req = 1'b0;
      chk_out("wdog_sticky", 3, 0, 20);
    end else begin
      chk_out("nowdog", 1, 1, 20);
      tick();
      chk_out("nowdog_next", 1, 1, 21);
    end
    chk_model("wdog_model");

    // Halt request on the expiry edge.
    async_reset("rst_coll");
    run_table("seq4");
    run_to(19, "pre_coll");
    core_hlt = 1'b1;
    tick();
    core_hlt = 1'b0;
    if (WD_ON) chk_out("collision", 3, 0, 20);
    else       chk_out("collision", 2, 0, 20);

    // Count saturation (only reachable without the watchdog).
    if (!WD_ON) begin
      async_reset("rst_sat");
      run_table("seq5");
      for (int i = 0; i < 260; i++) tick();
      chk_out("sat", 1, 1, CMAX);
      tick();
      chk_out("sat_hold", 1, 1, CMAX);
    end

    // Randomised run against the model.
    for (int i = 0; i < 2000; i++) begin
      res_n    = ($urandom_range(0, 79) != 0);
      core_hlt = ($urandom_range(0, 5) == 0);
      run_req  = ($urandom_range(0, 3) == 0);
      tick();
      chk_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
